car_collision_unit: RTL

Pixel-accurate frog-versus-car collision detector and life manager, sitting directly downstream of the five CarRow instances and the frog sprite. Each pixel, it compares the frog's opaque pixels against every car's opaque pixels, latching any overlap over the frame. At each frame boundary it runs the death, respawn and game-over state machine that drives the frog controller and the HUD.

---
 rtl/car_collision_unit_pkg.sv | 20 ++
 rtl/car_collision_unit_if.sv | 33 +++
 rtl/car_collision_unit_car_pixel_overlap.sv | 40 ++++
 rtl/car_collision_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/car_collision_unit_pkg.sv
// Shared definitions for the frogger collision logic.
// Contents: row/car geometry, pixel width, transparent palette index and the
// life-manager state enumeration.
package frogger_pkg;

    localparam int NUM_ROWS     = 5;
    localparam int CARS_PER_ROW = 4;
    localparam int PIX_W        = 5;
    localparam int ROW_W        = 3;

    localparam logic [PIX_W-1:0] TRANSPARENT = 5'd0;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } life_state_e;

endpackage

// File: rtl/car_collision_unit_if.sv
// Bundle of per-pixel sprite inputs, frame/level strobes and life-manager
// outputs that connect the collision unit to the video pipeline and HUD.
// slave  : collision unit side (pixel/strobe inputs, status outputs)
// master : driving side (video pipeline / frog controller / HUD)
interface car_collision_unit_if;
    import frogger_pkg::*;

    logic                                               frame_clk_rising_edge;
    logic                                               GoNextLevel;
    logic                                               is_frog;
    logic [PIX_W-1:0]                                   frog_data;
    logic [NUM_ROWS-1:0][CARS_PER_ROW-1:0]              is_car_rows;
    logic [NUM_ROWS-1:0][CARS_PER_ROW-1:0][PIX_W-1:0]   car_data;

    logic                                               frog_dead;
    logic                                               frog_respawn;
    logic [1:0]                                         lives;
    logic                                               game_over;
    logic [ROW_W-1:0]                                   hit_row;

    modport slave (
        input  frame_clk_rising_edge, GoNextLevel, is_frog, frog_data,
               is_car_rows, car_data,
        output frog_dead, frog_respawn, lives, game_over, hit_row
    );

    modport master (
        output frame_clk_rising_edge, GoNextLevel, is_frog, frog_data,
               is_car_rows, car_data,
        input  frog_dead, frog_respawn, lives, game_over, hit_row
    );

endinterface

// File: rtl/car_collision_unit_car_pixel_overlap.sv
// Combinational opaque-pixel overlap test between one sprite and all car rows.
// Inputs : frog_flag/frog_data (sprite flag aligned with its palette data),
//          car_flags/car_data (per row, per car, aligned likewise).
// Outputs: pix_hit (opaque sprite pixel over any opaque car pixel),
//          pix_row (lowest row index with an opaque car pixel here).
module car_pixel_overlap
    import frogger_pkg::*;
(
    input  logic                                             frog_flag,
    input  logic [PIX_W-1:0]                                 frog_data,
    input  logic [NUM_ROWS-1:0][CARS_PER_ROW-1:0]            car_flags,
    input  logic [NUM_ROWS-1:0][CARS_PER_ROW-1:0][PIX_W-1:0] car_data,
    output logic                                             pix_hit,
    output logic [ROW_W-1:0]                                 pix_row
);

    logic [NUM_ROWS-1:0] row_hit;

    always_comb begin
        row_hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < CARS_PER_ROW; c++) begin
                if (car_flags[r][c] && (car_data[r][c] != TRANSPARENT)) begin
                    row_hit[r] = 1'b1;
                end
            end
        end

        // Walk from the top row down so the lowest index wins.
        pix_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_hit[r]) begin
                pix_row = ROW_W'(r);
            end
        end

        pix_hit = frog_flag && (frog_data != TRANSPARENT) && (|row_hit);
    end

endmodule

// File: rtl/car_collision_unit.sv
// Frog-versus-car collision detector and life manager.
// Ports: Clk (system clock), Reset_n (async active-low reset),
//        bus (car_collision_unit_if.slave: pixel inputs, frame/level strobes,
//        frog_dead/frog_respawn/lives/game_over/hit_row outputs).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ALIVE     | frog playing, overlaps accumulate over each frame
// DYING     | death animation, counts frame edges, hits ignored
// RESPAWN   | single cycle, frog controller returns frog to start
// GAME_OVER | no lives left, absorbing until reset
module car_collision_unit
    import frogger_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 30
)
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    car_collision_unit_if.slave  bus
);

    localparam logic [1:0] ST_ALIVE     = ALIVE;
    localparam logic [1:0] ST_DYING     = DYING;
    localparam logic [1:0] ST_RESPAWN   = RESPAWN;
    localparam logic [1:0] ST_GAME_OVER = GAME_OVER;

    localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [5:0] DEATH_LOAD = 6'(DEATH_FRAMES - 1);

    logic                                    is_frog_d;
    logic [NUM_ROWS-1:0][CARS_PER_ROW-1:0]   is_car_rows_d;
    logic                                    pix_hit;
    logic [ROW_W-1:0]                        pix_row;
    logic                                    hit_acc;
    logic [ROW_W-1:0]                        hit_row_acc;
    logic                                    acc_block;
    logic [1:0]                              state;
    logic [1:0]                              lives_q;
    logic [5:0]                              frame_cnt;
    logic [ROW_W-1:0]                        hit_row_q;
    logic                                    dead_q;
    logic                                    respawn_q;
    logic                                    game_over_q;
    logic                                    frame_edge;
    logic                                    next_level;

    assign frame_edge = bus.frame_clk_rising_edge;
    assign next_level = bus.GoNextLevel && (state == ST_ALIVE);

    // Flags lead the palette ROM data by one clock.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_frog_d     <= 1'b0;
            is_car_rows_d <= '0;
        end else begin
            is_frog_d     <= bus.is_frog;
            is_car_rows_d <= bus.is_car_rows;
        end
    end

    car_pixel_overlap u_overlap (
        .frog_flag (is_frog_d),
        .frog_data (bus.frog_data),
        .car_flags (is_car_rows_d),
        .car_data  (bus.car_data),
        .pix_hit   (pix_hit),
        .pix_row   (pix_row)
    );

    // Outside ALIVE/RESPAWN nothing may accumulate; a level change wipes the frame.
    assign acc_block = (state == ST_DYING) || (state == ST_GAME_OVER) || next_level;

    // A hit on the frame edge restarts the accumulator set rather than clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_acc     <= 1'b0;
            hit_row_acc <= '0;
        end else if (acc_block) begin
            hit_acc     <= 1'b0;
        end else if (pix_hit && (frame_edge || !hit_acc)) begin
            hit_acc     <= 1'b1;
            hit_row_acc <= pix_row;
        end else if (frame_edge) begin
            hit_acc     <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_ALIVE;
            lives_q     <= LIVES_RST;
            frame_cnt   <= '0;
            hit_row_q   <= '0;
            dead_q      <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            case (state)
                ST_ALIVE: begin
                    if (frame_edge && !next_level && hit_acc) begin
                        if (lives_q != 2'd0) begin
                            lives_q <= lives_q - 2'd1;
                        end
                        hit_row_q <= hit_row_acc;
                        frame_cnt <= DEATH_LOAD;
                        dead_q    <= 1'b1;
                        state     <= ST_DYING;
                    end
                end
                ST_DYING: begin
                    if (frame_edge) begin
                        if (frame_cnt == 6'd0) begin
                            dead_q <= 1'b0;
                            if (lives_q == 2'd0) begin
                                game_over_q <= 1'b1;
                                state       <= ST_GAME_OVER;
                            end else begin
                                respawn_q <= 1'b1;
                                state     <= ST_RESPAWN;
                            end
                        end else begin
                            frame_cnt <= frame_cnt - 6'd1;
                        end
                    end
                end
                ST_RESPAWN: begin
                    state <= ST_ALIVE;
                end
                default: begin
                    state <= ST_GAME_OVER;
                end
            endcase
        end
    end

    assign bus.frog_dead    = dead_q;
    assign bus.frog_respawn = respawn_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = game_over_q;
    assign bus.hit_row      = hit_row_q;

endmodule
